// File: rtl/sid_wr_frontend.sv
// sid_wr_frontend
// Host register-write front end. Brings the asynchronous write strobe into the
// clk domain, turns each rising edge into one captured {voice, addr, data}
// word, and queues the words in a small first-word-fall-through FIFO. The
// register file drains the FIFO over a valid/ready handshake.

module sid_wr_frontend #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_strobe_in,
   input  logic [2:0]               addr_in,
   input  logic [1:0]               voice_in,
   input  logic [7:0]               data_in,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   output logic [1:0]               wr_voice,
   output logic [2:0]               wr_addr,
   output logic [7:0]               wr_data,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   input  logic                     ovf_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [CW-1:0] CNT_ONE  = 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic          s1, s2, s3;
   logic          rise;
   logic          pop;
   logic          push;
   logic          full;
   logic          ovf_set;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [12:0]   mem [DEPTH];

   // Strobe synchroniser; flops come out of reset high so a strobe already
   // asserted at reset release must go low before it can produce a write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= wr_strobe_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // The host holds address/voice/data stable around the strobe edge, so the
   // raw inputs can be captured directly when the synchronised edge appears.
   assign rise    = s2 & ~s3;
   assign full    = (count == CNT_FULL);
   assign pop     = wr_valid & wr_ready;
   assign push    = rise & (~full | pop);
   assign ovf_set = rise & full & ~pop;

   // Storage array; a push while full-and-popping lands in the slot the
   // head is vacating, because wr_ptr equals rd_ptr in that state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= {voice_in, addr_in, data_in};
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two; count tracks
   // occupancy so full and empty are unambiguous.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag; a new drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (ovf_set) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   assign wr_valid                    = (count != '0);
   assign fifo_level                  = count;
   assign {wr_voice, wr_addr, wr_data} = mem[rd_ptr];

endmodule

// File: tb/tb_sid_wr_frontend.sv
// tb_sid_wr_frontend
// Scoreboard bench for sid_wr_frontend: each accepted host write is queued
// when driven, and a negedge monitor pops and compares on every handshake.

module tb_sid_wr_frontend;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_strobe_in;
   logic [2:0] addr_in;
   logic [1:0] voice_in;
   logic [7:0] data_in;
   logic       wr_valid;
   logic       wr_ready;
   logic [1:0] wr_voice;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [2:0] fifo_level;
   logic       overflow;
   logic       ovf_clr;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [12:0] sb [$];

   logic        prev_hold = 1'b0;
   logic [12:0] prev_head = '0;
   logic [12:0] exp_word;

   sid_wr_frontend #(.DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_strobe_in (wr_strobe_in),
      .addr_in      (addr_in),
      .voice_in     (voice_in),
      .data_in      (data_in),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_voice     (wr_voice),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .ovf_clr      (ovf_clr)
   );

   // 100 MHz-style bench clock; absolute rate is irrelevant to the design.
   always #5 clk = ~clk;

   // Absolute time limit so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Handshake monitor: pops the scoreboard on every accepted head and checks
   // the head stays frozen while it is valid but not accepted.
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            n_cmp++;
            if (wr_valid !== 1'b1 || {wr_voice, wr_addr, wr_data} !== prev_head) begin
               n_fail++;
               $display("[TB] FAIL head_hold: got valid=%b head=%h, expected valid=1 head=%h",
                        wr_valid, {wr_voice, wr_addr, wr_data}, prev_head);
            end
         end
         if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL unexpected_write: got head=%h, expected no write",
                        {wr_voice, wr_addr, wr_data});
            end else begin
               exp_word = sb.pop_front();
               if ({wr_voice, wr_addr, wr_data} !== exp_word) begin
                  n_fail++;
                  $display("[TB] FAIL head_word: got %h, expected %h",
                           {wr_voice, wr_addr, wr_data}, exp_word);
               end
            end
         end
         prev_hold = (wr_valid === 1'b1) && (wr_ready === 1'b0);
         prev_head = {wr_voice, wr_addr, wr_data};
      end
   end

   // One full host write obeying the host timing contract: data set up one
   // clock early, strobe high 3 clocks, low 3 clocks, data held throughout.
   task automatic write_entry(input logic [1:0] v, input logic [2:0] a,
                              input logic [7:0] d, input bit accept);
      @(posedge clk); #1;
      voice_in = v;
      addr_in  = a;
      data_in  = d;
      if (accept) sb.push_back({v, a, d});
      @(posedge clk); #1;
      wr_strobe_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 wr_strobe_in = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   // Sets up data and raises the strobe; the next posedge is the first sample.
   task automatic raise_strobe(input logic [1:0] v, input logic [2:0] a,
                               input logic [7:0] d);
      @(posedge clk); #1;
      voice_in = v;
      addr_in  = a;
      data_in  = d;
      @(posedge clk); #1;
      wr_strobe_in = 1'b1;
   endtask

   task automatic drain_and_check(input string tag);
      @(posedge clk); #1 wr_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (fifo_level !== 3'd0 || wr_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL %s_drain_level: got level=%0d valid=%b, expected level=0 valid=0",
                  tag, fifo_level, wr_valid);
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL %s_drain_count: got %0d writes missing, expected 0", tag, sb.size());
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      wr_strobe_in = 1'b0;
      addr_in      = '0;
      voice_in     = '0;
      data_in      = '0;
      wr_ready     = 1'b0;
      ovf_clr      = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (wr_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: got valid=%b level=%0d ovf=%b, expected 0/0/0",
                  wr_valid, fifo_level, overflow);
      end
      n_cmp++;
      if ({wr_voice, wr_addr, wr_data} !== 13'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_head: got %h, expected 0000", {wr_voice, wr_addr, wr_data});
      end
      @(posedge clk); #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (wr_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_no_write: got valid=%b, expected 0", wr_valid);
      end
   endtask

   task automatic test_single_write();
      logic exp_valid [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      wr_ready = 1'b1;
      sb.push_back({2'd0, 3'd0, 8'h09});
      raise_strobe(2'd0, 3'd0, 8'h09);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         n_cmp++;
         if (wr_valid !== exp_valid[i]) begin
            n_fail++;
            $display("[TB] FAIL single_valid_cycle%0d: got %b, expected %b", i, wr_valid, exp_valid[i]);
         end
         if (i == 2) begin
            n_cmp++;
            if ({wr_voice, wr_addr, wr_data} !== {2'd0, 3'd0, 8'h09}) begin
               n_fail++;
               $display("[TB] FAIL single_head: got %h, expected %h",
                        {wr_voice, wr_addr, wr_data}, {2'd0, 3'd0, 8'h09});
            end
         end
      end
      wr_strobe_in = 1'b0;
      repeat (3) @(posedge clk);
      drain_and_check("single");
   endtask

   task automatic test_fill_overflow();
      @(posedge clk); #1 wr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         write_entry(2'd0, 3'd1, 8'(i + 1), i < 4);
      end
      @(negedge clk);
      n_cmp++;
      if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL fill_level_ovf: got level=%0d ovf=%b, expected 4/1", fifo_level, overflow);
      end
      drain_and_check("fill");
      @(posedge clk); #1 ovf_clr = 1'b1;
      @(posedge clk); #1 ovf_clr = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL fill_ovf_clear: got %b, expected 0", overflow);
      end
   endtask

   task automatic test_full_push_pop();
      @(posedge clk); #1 wr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         write_entry(2'd1, 3'd2, 8'h11 + 8'(i), 1'b1);
      end
      sb.push_back({2'd1, 3'd2, 8'h15});
      raise_strobe(2'd1, 3'd2, 8'h15);
      @(posedge clk);
      @(posedge clk); #1 wr_ready = 1'b1;
      @(posedge clk); #1 wr_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL full_pp_level_ovf: got level=%0d ovf=%b, expected 4/0", fifo_level, overflow);
      end
      wr_strobe_in = 1'b0;
      repeat (3) @(posedge clk);
      drain_and_check("full_pp");
   endtask

   task automatic test_back_to_back();
      bit done = 1'b0;
      int low_run = 0;
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               write_entry(2'd3, 3'd3, 8'h1F ^ 8'(i), 1'b1);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               if (low_run >= 2) begin
                  wr_ready = 1'b1;
                  low_run  = 0;
               end else begin
                  wr_ready = 1'($urandom_range(0, 1));
                  if (wr_ready) low_run = 0;
                  else          low_run++;
               end
            end
         end
      join
      drain_and_check("b2b");
   endtask

   task automatic test_reset_strobe_high();
      @(posedge clk); #1 wr_ready = 1'b0;
      write_entry(2'd2, 3'd4, 8'h31, 1'b1);
      write_entry(2'd2, 3'd5, 8'h32, 1'b1);
      raise_strobe(2'd2, 3'd6, 8'h33);
      @(posedge clk); #1;
      rst = 1'b1;
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if (wr_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL rst_high_idle%0d: got valid=%b level=%0d, expected 0/0",
                     i, wr_valid, fifo_level);
         end
      end
      @(posedge clk); #1 wr_strobe_in = 1'b0;
      repeat (3) @(posedge clk);
      write_entry(2'd2, 3'd7, 8'h34, 1'b1);
      drain_and_check("rst_high");
   endtask

   task automatic test_ovf_clr_collision();
      @(posedge clk); #1 wr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         write_entry(2'd0, 3'd6, 8'h40 + 8'(i), 1'b1);
      end
      @(negedge clk);
      n_cmp++;
      if (overflow !== 1'b0 || fifo_level !== 3'd4) begin
         n_fail++;
         $display("[TB] FAIL ovfclr_pre: got ovf=%b level=%0d, expected 0/4", overflow, fifo_level);
      end
      raise_strobe(2'd0, 3'd6, 8'hA5);
      @(posedge clk);
      @(posedge clk); #1 ovf_clr = 1'b1;
      @(posedge clk); #1 ovf_clr = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
         n_fail++;
         $display("[TB] FAIL ovfclr_set_wins: got ovf=%b level=%0d, expected 1/4", overflow, fifo_level);
      end
      @(posedge clk); #1 ovf_clr = 1'b1;
      @(posedge clk); #1 ovf_clr = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL ovfclr_alone: got %b, expected 0", overflow);
      end
      wr_strobe_in = 1'b0;
      repeat (3) @(posedge clk);
      drain_and_check("ovfclr");
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_single_write();
      test_fill_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_reset_strobe_high();
      test_ovf_clr_collision();
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sid_wr_frontend.md
# sid_wr_frontend

Host register-write front end for `tt_um_sid`. Sits between the pads (`ui_in`/`uio_in`) and the voice/filter register file. It synchronises the asynchronous write strobe and detects its rising edge. On each edge it captures voice, address and data into a small FIFO. The register file drains the FIFO over a valid/ready handshake, so a host write never collides with the time-multiplexed voice engine's register-update slot.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock, ~12 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_strobe_in`  in  1  raw write strobe (`ui_in[7]`), asynchronous to `clk`.
- `addr_in`  in  3  register address (`ui_in[2:0]`).
- `voice_in`  in  2  voice select (`ui_in[4:3]`); 3 = filter/global bank.
- `data_in`  in  8  write data (`uio_in`).
- `wr_valid`  out  1  FIFO head holds a write.
- `wr_ready`  in  1  register file accepts the head this cycle.
- `wr_voice`  out  2  head voice.
- `wr_addr`  out  3  head address.
- `wr_data`  out  8  head data.
- `fifo_level`  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was dropped because the FIFO was full.
- `ovf_clr`  in  1  synchronous clear of `overflow`.

## Operation
- Synchroniser: three flops in series, `s1 <= wr_strobe_in`, `s2 <= s1`, `s3 <= s2`. `rise = s2 & ~s3`.
- All three flops reset to 1. A strobe that is already high at reset release produces no write. The strobe must be seen low first.
- Capture: in the cycle where `rise=1`, `{voice_in, addr_in, data_in}` is sampled directly from the inputs and pushed.
- Host contract: `addr_in`/`voice_in`/`data_in` are stable from ≥1 clk before the strobe rises until ≥4 clk after it rises. The strobe is high ≥2 clk and low ≥2 clk between writes. Under this contract the captured value is never metastable.
- FIFO: circular buffer, DEPTH entries. Write pointer, read pointer and a count register. Pointers wrap modulo DEPTH.
- Head outputs:
  - `wr_voice`/`wr_addr`/`wr_data` show the entry at the read pointer (first-word fall-through).
  - `wr_valid = (count != 0)`. `fifo_level = count`.
  - Head outputs are don't-care while `wr_valid=0`, but must be stable while `wr_valid=1`.
- Pop: on `wr_valid & wr_ready`.
- Push:
  - Accepted when `rise` and (count < DEPTH, or a pop occurs in the same cycle).
  - Push and pop together when full: both happen, count stays DEPTH, and the new entry lands in the freed slot.
  - Push and pop together when count=1: count stays 1, and the head advances to the new entry.
- Overflow: `rise` while count = DEPTH and no pop that cycle → the entry is dropped, the FIFO is unchanged, and `overflow` is set. `ovf_clr` clears it. If a set and `ovf_clr` occur in the same cycle, set wins.
- `wr_valid` never drops without a pop. The head entry never changes while `wr_valid & ~wr_ready`.

## Timing
- Reset values:
  - `wr_valid=0`, `fifo_level=0`, `overflow=0`.
  - `wr_voice/wr_addr/wr_data = 0`, with storage cleared.
  - Pointers 0; s1..s3 = 1.
- Reset asserted mid-operation: all queued writes are discarded at once, and any in-flight strobe edge is lost.
- Latency: strobe first sampled high at posedge k → `rise` during cycle k+1..k+2 → push at posedge k+2 → `wr_valid=1` after posedge k+2 (when the FIFO was empty).
- Pop with `wr_ready` held high: the entry is consumed at the first posedge with `wr_valid=1`, and the next entry is visible the following cycle.
- Sustained throughput: one write per strobe period (≥4 clk), which is well within the pop rate.

## Test plan
- Single write: voice 0, addr 0, data 0x09 with `wr_ready=1` → `wr_valid` is high for exactly 1 cycle, starting 2 posedges after the first high strobe sample, carrying {0,0,0x09}. Level returns to 0.
- Fill and overflow: `wr_ready=0`, five writes with data 0x01..0x05 → level reaches 4 and `overflow=1`. Then `wr_ready=1` → the drain yields 0x01,0x02,0x03,0x04 in order, and 0x05 is absent.
- Full push+pop: FIFO full, strobe edge coincides with a pop → level stays 4, `overflow` stays 0. The drain order ends with the new entry.
- Backpressure stability: `wr_ready` toggled pseudo-randomly over 12 writes (voice 3, addr 3, data 0x1F) → the head outputs never change while valid & !ready. The sequence is identical to the write order.
- Reset with strobe held high: assert `rst` with 2 entries queued and the strobe high, then release → level=0, `wr_valid=0`, no write while the strobe stays high. The next low→high transition yields exactly one write.
- `ovf_clr` simultaneous with an overflow event → `overflow` remains 1. `ovf_clr` alone the next cycle → `overflow=0`.
